imem_loader: RTL and testbench

//   Write-side counterpart of the instruction memory. Receives a program image as a

---
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs a length-prefixed, XOR-checksummed image into
// 32-bit words, writes them to instruction memory and holds the CPU until it checks out.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int              IDXW    = $clog2(DEPTH + 1);
  localparam logic [16:0]     DEPTH_W = 17'(DEPTH);
  localparam logic [IDXW-1:0] ONE     = IDXW'(1);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR
  } state_t;

  state_t          state, nextState;
  logic [7:0]      lenHi;
  logic [IDXW-1:0] wordTotal;
  logic [IDXW-1:0] wordIdx;
  logic [1:0]      byteCnt;
  logic [23:0]     shiftReg;
  logic [7:0]      csum;
  logic            xfer;
  logic            startOk;
  logic            lenTooBig;
  logic            lastWord;
  logic [15:0]     lenWord;

  assign xfer      = in_valid & in_ready;
  assign startOk   = start && (state == IDLE || state == DONE || state == ERR);
  assign lenWord   = {lenHi, in_data};
  assign lenTooBig = {1'b0, lenWord} > DEPTH_W;
  assign lastWord  = (byteCnt == 2'd3) && (wordIdx == wordTotal - ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE, ERR: if (startOk) nextState = LEN_HI;
      LEN_HI:          if (xfer) nextState = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (lenTooBig)          nextState = ERR;
          else if (lenWord == 0)  nextState = CHECK;
          else                    nextState = DATA;
        end
      end
      DATA:            if (xfer && lastWord) nextState = CHECK;
      CHECK:           if (xfer) nextState = (in_data == csum) ? DONE : ERR;
      default:         nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA, CHECK: in_ready = 1'b1;
      default:                     in_ready = 1'b0;
    endcase
  end

  // Datapath: the checksum byte itself is never folded into the running XOR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lenHi     <= '0;
      wordTotal <= '0;
      wordIdx   <= '0;
      byteCnt   <= '0;
      shiftReg  <= '0;
      csum      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (startOk) begin
        done     <= 1'b0;
        error    <= 1'b0;
        csum     <= '0;
        wordIdx  <= '0;
        byteCnt  <= '0;
        shiftReg <= '0;
        cpu_hold <= 1'b1;
      end else if (xfer) begin
        if (state != CHECK) csum <= csum ^ in_data;
        case (state)
          LEN_HI: lenHi <= in_data;
          LEN_LO: begin
            wordTotal <= lenWord[IDXW-1:0];
            if (lenTooBig) error <= 1'b1;
          end
          DATA: begin
            byteCnt  <= byteCnt + 2'd1;
            shiftReg <= {shiftReg[15:0], in_data};
            if (byteCnt == 2'd3) begin
              wr_en   <= 1'b1;
              wr_data <= {shiftReg, in_data};
              wr_addr <= BASE_ADDR + {{(30-IDXW){1'b0}}, wordIdx, 2'b00};
              wordIdx <= wordIdx + ONE;
            end
          end
          CHECK: begin
            if (in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good load, bad checksum, oversize, empty image,
// stalled stream and reset in the middle of a load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] wAddr [64];
  logic [31:0] wData [64];
  int          wCount = 0;
  int          wideCount = 0;
  logic        prevWrEn = 1'b0;

  logic [7:0]  stream [11];

  imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Records every write strobe and flags any strobe lasting more than one cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wCount < 64) begin
        wAddr[wCount] = wr_addr;
        wData[wCount] = wr_data;
      end
      wCount = wCount + 1;
      if (prevWrEn) wideCount = wideCount + 1;
    end
    prevWrEn = wr_en;
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL byte_accept: in_ready got 0 expected 1 for byte %h", b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic loadCase1(input logic [7:0] last);
    stream = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h04,
               8'hAC, 8'h02, 8'h00, 8'h04, 8'h8E};
    stream[10] = last;
  endtask

  task automatic test_reset();
    #12;
    testsRun++;
    if ({wr_en, cpu_hold, done, error, in_ready} !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {wr_en, cpu_hold, done, error, in_ready});
    end
    testsRun++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_bus: got %h/%h expected 0/0", wr_addr, wr_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_ok(input int gap);
    int base = wCount;
    int wide = wideCount;
    loadCase1(8'h8E);
    pulseStart();
    testsRun++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ok_start: hold/done got %b%b expected 10", cpu_hold, done);
    end
    for (int i = 0; i < 11; i++) applyStimulus(stream[i], gap);
    repeat (2) @(negedge clk);
    testsRun++;
    if (wCount - base !== 2) begin
      testsFailed++;
      $display("[TB] FAIL ok_wcount: got %0d expected 2", wCount - base);
    end
    testsRun++;
    if (wAddr[base] !== 32'h0 || wData[base] !== 32'h20020004) begin
      testsFailed++;
      $display("[TB] FAIL ok_word0: got %h@%h expected 20020004@00000000", wData[base], wAddr[base]);
    end
    testsRun++;
    if (wAddr[base+1] !== 32'h4 || wData[base+1] !== 32'hAC020004) begin
      testsFailed++;
      $display("[TB] FAIL ok_word1: got %h@%h expected ac020004@00000004", wData[base+1], wAddr[base+1]);
    end
    testsRun++;
    if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL ok_status: done/err/hold/rdy got %b expected 1000", {done, error, cpu_hold, in_ready});
    end
    testsRun++;
    if (wideCount !== wide) begin
      testsFailed++;
      $display("[TB] FAIL ok_pulse_width: wide strobes got %0d expected 0", wideCount - wide);
    end
  endtask

  task automatic test_bad_checksum();
    int base = wCount;
    loadCase1(8'h8F);
    pulseStart();
    for (int i = 0; i < 11; i++) applyStimulus(stream[i], 0);
    repeat (2) @(negedge clk);
    testsRun++;
    if (wCount - base !== 2) begin
      testsFailed++;
      $display("[TB] FAIL bad_wcount: got %0d expected 2", wCount - base);
    end
    testsRun++;
    if ({done, error, cpu_hold, in_ready} !== 4'b0110) begin
      testsFailed++;
      $display("[TB] FAIL bad_status: done/err/hold/rdy got %b expected 0110", {done, error, cpu_hold, in_ready});
    end
  endtask

  task automatic test_oversize();
    int base = wCount;
    pulseStart();
    applyStimulus(8'h04, 0);
    applyStimulus(8'h01, 0);
    @(negedge clk);
    testsRun++;
    if ({done, error, cpu_hold, in_ready} !== 4'b0110) begin
      testsFailed++;
      $display("[TB] FAIL big_status: done/err/hold/rdy got %b expected 0110", {done, error, cpu_hold, in_ready});
    end
    repeat (4) @(negedge clk);
    testsRun++;
    if (wCount - base !== 0) begin
      testsFailed++;
      $display("[TB] FAIL big_wcount: got %0d expected 0", wCount - base);
    end
  endtask

  task automatic test_empty();
    int base = wCount;
    pulseStart();
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 0);
    repeat (2) @(negedge clk);
    testsRun++;
    if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL empty_status: done/err/hold/rdy got %b expected 1000", {done, error, cpu_hold, in_ready});
    end
    testsRun++;
    if (wCount - base !== 0) begin
      testsFailed++;
      $display("[TB] FAIL empty_wcount: got %0d expected 0", wCount - base);
    end
  endtask

  task automatic test_reset_mid_load();
    int base = wCount;
    loadCase1(8'h8E);
    pulseStart();
    for (int i = 0; i < 6; i++) applyStimulus(stream[i], 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    testsRun++;
    if ({wr_en, cpu_hold, done, error, in_ready} !== 5'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_outputs: flags %b addr %h data %h expected all 0",
               {wr_en, cpu_hold, done, error, in_ready}, wr_addr, wr_data);
    end
    testsRun++;
    if (wCount - base !== 1 || wAddr[base] !== 32'h0 || wData[base] !== 32'h20020004) begin
      testsFailed++;
      $display("[TB] FAIL midrst_writes: got %0d writes, first %h@%h expected 1 write 20020004@00000000",
               wCount - base, wData[base], wAddr[base]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_load_ok(0);
  endtask

  initial begin
    test_reset();
    test_load_ok(0);
    test_bad_checksum();
    test_oversize();
    test_empty();
    test_load_ok(3);
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
